// File: rtl/keyentry.sv
// Keypad entry: assembles a multi-digit BCD number from synckey codes
// and commits it on ENTER as a one-cycle-valid value.
module keyentry #(
    parameter int NDIG       = 4,
    parameter int CODE_ENTER = 16,
    parameter int CODE_CLEAR = 17,
    parameter int CODE_BKSP  = 18
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [4:0]                 keycode,
    input  logic                       strb,
    output logic [4*NDIG-1:0]          bcd,
    output logic [$clog2(NDIG+1)-1:0]  ndig,
    output logic                       overflow,
    output logic [4*NDIG-1:0]          value,
    output logic                       value_valid
);

    localparam int NW = $clog2(NDIG+1);

    typedef enum logic [1:0] {EMPTY, ENTRY, FULL} state_t;

    state_t state;
    state_t state_nxt;
    logic   strb_q;
    logic   ev;
    logic   is_digit;
    logic   act_push;
    logic   act_ovf;
    logic   act_pop;
    logic   act_clr;
    logic   act_commit;

    assign ev       = strb & ~strb_q;
    assign is_digit = keycode < 5'd10;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: state mirrors the digit count
    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            act_clr, act_commit: state_nxt = EMPTY;
            act_push: state_nxt = (ndig == NW'(NDIG-1)) ? FULL : ENTRY;
            act_pop:  state_nxt = (ndig == NW'(1)) ? EMPTY : ENTRY;
            default:  state_nxt = state;
        endcase
    end

    // Output decode: one action per strobe event
    always_comb begin
        act_push   = 1'b0;
        act_ovf    = 1'b0;
        act_pop    = 1'b0;
        act_clr    = 1'b0;
        act_commit = 1'b0;
        if (ev) begin
            act_push   = is_digit && (state != FULL);
            act_ovf    = is_digit && (state == FULL);
            act_pop    = (keycode == 5'(CODE_BKSP)) && (state != EMPTY);
            act_clr    = (keycode == 5'(CODE_CLEAR));
            act_commit = (keycode == 5'(CODE_ENTER)) && (state != EMPTY);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strb_q      <= 1'b0;
            bcd         <= '0;
            ndig        <= '0;
            overflow    <= 1'b0;
            value       <= '0;
            value_valid <= 1'b0;
        end else begin
            strb_q      <= strb;
            value_valid <= act_commit;
            if (act_commit) begin
                value <= bcd;
            end
            if (act_clr || act_commit) begin
                bcd      <= '0;
                ndig     <= '0;
                overflow <= 1'b0;
            end else if (act_push) begin
                bcd  <= {bcd[4*NDIG-5:0], keycode[3:0]};
                ndig <= ndig + NW'(1);
            end else if (act_ovf) begin
                overflow <= 1'b1;
            end else if (act_pop) begin
                bcd  <= {4'h0, bcd[4*NDIG-1:4]};
                ndig <= ndig - NW'(1);
            end
        end
    end

endmodule
